rv32i_uart_tx: RTL
==================

// Module: rv32i_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter on the rv32i_soc data bus: responder to the core's load/store initiator.
//  Stores to TXDATA push bytes into a small FIFO; an 8N1 serialiser drains it onto o_uart_tx.
//  STATUS exposes busy/full/empty/overflow for polling firmware. Sits beside the data memory in the SoC.
// PARAMETERS
//  CLK_FREQ_MHZ   100     core clock frequency in MHz
//  BAUD_RATE      115200  serial bit rate
//  CLKS_PER_BIT   CLK_FREQ_MHZ*1_000_000/BAUD_RATE (=868)  cycles per serial bit; bench may override
//  FIFO_DEPTH     4       TX FIFO entries (power of 2, >=2)
// PORTS
//  i_clk       in   1   core clock
//  i_rst       in   1   synchronous, active-high reset
//  i_wb_cyc    in   1   bus cycle active
//  i_wb_stb    in   1   request strobe (peripheral already address-selected)
//  i_wb_we     in   1   1=store, 0=load
//  i_wb_addr   in   32  byte address; only bit [2] decoded (0=TXDATA, 1=STATUS)
//  i_wb_data   in   32  store data
//  i_wb_sel    in   4   byte enables
//  o_wb_ack    out  1   one-cycle acknowledge
//  o_wb_stall  out  1   tied 0
//  o_wb_data   out  32  load data, valid with o_wb_ack
//  o_uart_tx   out  1   serial line, idle high
// BEHAVIOUR
//  Clock/reset: one clock i_clk; reset i_rst is synchronous and active-high.
//  Reset: o_wb_ack=0, o_wb_data=0, o_uart_tx=1, FSM=IDLE, FIFO empty, overflow=0, bit/baud counters=0.
//  Bus: request = i_wb_cyc & i_wb_stb; o_wb_ack=1 exactly the cycle after every request, never stalls.
//   Back-to-back requests each acked (1-cycle latency, full throughput).
//  TXDATA store with i_wb_sel[0]=1: push i_wb_data[7:0] if not full; sel[0]=0 -> no push, still acked.
//  Store when full: byte dropped, overflow<=1 (sticky), ack still given. Full evaluated on pre-pop
//   count: push rejected even if FSM pops same cycle.
//  STATUS store with i_wb_data[3]=1 clears overflow; other bits ignored.
//  Loads: TXDATA reads 0; STATUS = {28'b0, overflow, fifo_empty, fifo_full, tx_busy} sampled at request.
//  tx_busy = FSM!=IDLE. Loads/STATUS stores have no side effect on FIFO.
//  FIFO: circular buffer, wr/rd pointers wrap at FIFO_DEPTH, count 0..FIFO_DEPTH; push+pop same cycle
//   (not full) leaves count unchanged.
//  FSM: IDLE -> START -> DATA -> STOP -> (IDLE | START).
//   IDLE: o_uart_tx=1; if FIFO non-empty pop into shift reg, go START.
//   START: o_uart_tx=0 for CLKS_PER_BIT cycles.
//   DATA: 8 bits LSB first, each CLKS_PER_BIT cycles; 3-bit index.
//   STOP: o_uart_tx=1 for CLKS_PER_BIT cycles; on last cycle, FIFO non-empty -> pop, START (no idle gap);
//    else IDLE.
//  Timing: store acked at T+1 into empty FIFO while IDLE -> count=1 at T+1, pop at T+1,
//   o_uart_tx falls at T+2. Frame = 10*CLKS_PER_BIT cycles; consecutive frames contiguous.
//  Baud counter counts 0..CLKS_PER_BIT-1, reloads per bit; width $clog2(CLKS_PER_BIT).
//  o_uart_tx registered (glitch-free).
//  Reset mid-frame: line high next cycle, FIFO flushed, queued bytes lost.
// TESTING (bench overrides CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  Reset: hold i_rst 3 cycles mid-frame -> o_uart_tx=1, STATUS reads 0x4, no further edges.
//  Single byte: store 0x55 to TXDATA -> ack next cycle; line low at T+2; bits 1,0,1,0,1,0,1,0 then stop;
//   40 cycles total.
//  Burst: 4 stores 0x01..0x04 back-to-back -> 4 acks, 160-cycle contiguous stream, STATUS busy until end.
//  Overflow: 6 stores back-to-back -> first byte popped, next 4 queued, 6th dropped; STATUS bit3=1;
//   store 0x8 to STATUS clears it.
//  Byte enable: store with sel=4'b0010 to TXDATA -> acked, no frame, fifo_empty stays 1.
//  Status poll: load STATUS during frame -> o_wb_data=0x1 (busy, FIFO neither full nor empty flags set
//   as appropriate), ack 1 cycle after strobe.

Source files
------------

// File: rtl/rv32i_uart_tx_if.sv
// Data-bus port bundle for the UART transmitter.
// The core is the master and the peripheral is the slave.
interface rv32i_uart_tx_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        ack;
  logic        stall;
  logic [31:0] rdata;

  modport master (
    output cyc, stb, we, addr, wdata, sel,
    input  ack, stall, rdata
  );

  modport slave (
    input  cyc, stb, we, addr, wdata, sel,
    output ack, stall, rdata
  );
endinterface

// File: rtl/rv32i_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// TXDATA at bit2=0 and STATUS at bit2=1; single-cycle ack.
module rv32i_uart_tx #(
  parameter int CLK_FREQ_MHZ = 100,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT =
    CLK_FREQ_MHZ * 1_000_000 / BAUD_RATE,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  rv32i_uart_tx_if.slave bus,
  output logic o_uart_tx
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CLAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] CFULL =
    (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;

  state_t state, nxt;

  logic          req, wr_tx, wr_st, rd_st;
  logic          push, pop, full, empty, busy;
  logic          overflow;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    idx, idx_d;
  logic [7:0]    sh, sh_d;
  logic          tx_d, last;
  logic          unused_bits;

  assign req   = bus.cyc & bus.stb;
  assign wr_tx = req & bus.we & ~bus.addr[2]
               & bus.sel[0];
  assign wr_st = req & bus.we & bus.addr[2];
  assign rd_st = req & ~bus.we & bus.addr[2];

  assign full  = (count == CFULL);
  assign empty = (count == '0);
  assign busy  = (state != IDLE);
  assign push  = wr_tx & ~full;
  assign last  = (cnt == CLAST);

  assign bus.stall = 1'b0;

  assign unused_bits = ^{bus.addr[31:3],
                         bus.addr[1:0],
                         bus.wdata[31:8],
                         bus.sel[3:1]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.ack   <= 1'b0;
      bus.rdata <= '0;
      overflow  <= 1'b0;
    end else begin
      bus.ack   <= req;
      bus.rdata <= rd_st
        ? {28'b0, overflow, empty, full, busy}
        : 32'b0;
      if (wr_st & bus.wdata[3])
        overflow <= 1'b0;
      else if (wr_tx & full)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push)
      mem[wp] <= bus.wdata[7:0];
  end

  // full is taken from the pre-pop count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      o_uart_tx <= 1'b1;
    end else begin
      state     <= nxt;
      cnt       <= cnt_d;
      idx       <= idx_d;
      sh        <= sh_d;
      o_uart_tx <= tx_d;
    end
  end

  always_comb begin
    nxt   = state;
    cnt_d = cnt;
    idx_d = idx;
    sh_d  = sh;
    pop   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop  = 1'b1;
          sh_d = mem[rp];
          nxt  = START;
        end
      end
      START: begin
        cnt_d = cnt + 1'b1;
        if (last) begin
          cnt_d = '0;
          idx_d = '0;
          nxt   = DATA;
        end
      end
      DATA: begin
        cnt_d = cnt + 1'b1;
        if (last) begin
          cnt_d = '0;
          sh_d  = {1'b0, sh[7:1]};
          idx_d = idx + 1'b1;
          if (idx == 3'd7)
            nxt = STOP;
        end
      end
      STOP: begin
        cnt_d = cnt + 1'b1;
        if (last) begin
          cnt_d = '0;
          nxt   = IDLE;
          // chain the next frame with no idle gap
          if (!empty) begin
            pop  = 1'b1;
            sh_d = mem[rp];
            nxt  = START;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    unique case (nxt)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule
